rom_bus_arbiter: RTL

- Owns the single-port instruction SRAM. Arbitrates between the IF fetch port (PC stage) and the EX/MEM data port (loads and stores that target ROM space).
- Sequences each SRAM cycle with setup, access-wait and hold phases, returns read data, and raises a stall request to CTRL while any requester is unserved.
- Sits between the PC/ID/MEM stages and the board SRAM pins.

---
 rtl/rom_bus_arbiter_pkg.sv | 35 +++
 rtl/rom_bus_arbiter_sram_cycle_timer.sv | 41 ++++
 rtl/rom_bus_arbiter.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/rom_bus_arbiter_pkg.sv
// Shared encodings for the instruction-SRAM arbiter: FSM states, bus owners,
// strobe levels and the fetch/data grant rule.
package rom_bus_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_SETUP  = 2'd1,
      ARB_ACCESS = 2'd2,
      ARB_HOLD   = 2'd3
   } arb_state_e;

   typedef enum logic {
      OWN_FETCH = 1'b0,
      OWN_DATA  = 1'b1
   } owner_e;

   localparam logic STROBE_ACTIVE   = 1'b0;
   localparam logic STROBE_INACTIVE = 1'b1;

   localparam int unsigned WAIT_CNT_W = 4;

   // With both ports pending, the one that did not own the previous cycle wins.
   function automatic owner_e pick_owner(input logic   if_req,
                                         input logic   d_req,
                                         input owner_e last_owner);
      if (if_req && d_req) begin
         return (last_owner == OWN_FETCH) ? OWN_DATA : OWN_FETCH;
      end else if (d_req) begin
         return OWN_DATA;
      end else begin
         return OWN_FETCH;
      end
   endfunction

endpackage

// File: rtl/rom_bus_arbiter_sram_cycle_timer.sv
// Access-phase wait counter: loaded on entry to ACCESS, counts down to zero,
// and flags the last ACCESS cycle.
module rom_bus_arbiter_sram_cycle_timer
   import rom_bus_arbiter_pkg::*;
#(
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic load_i,
   input  logic en_i,
   output logic done_o
);

   localparam logic [WAIT_CNT_W-1:0] LOAD_VAL = WAIT_CNT_W'(WAIT_CYCLES - 1);

   logic [WAIT_CNT_W-1:0] cnt_q;
   logic [WAIT_CNT_W-1:0] cnt_d;

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = LOAD_VAL;
      end else if (en_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done_o = (cnt_q == '0);

endmodule

// File: rtl/rom_bus_arbiter.sv
// Single-port instruction SRAM arbiter between the IF fetch port and the EX/MEM
// data port; sequences SETUP/ACCESS/HOLD cycles and drives the stall request.
module rom_bus_arbiter
   import rom_bus_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic [DATA_W-1:0] if_rdata_o,
   output logic              if_valid_o,
   input  logic              d_req_i,
   input  logic              d_we_i,
   input  logic [ADDR_W-1:0] d_addr_i,
   input  logic [DATA_W-1:0] d_wdata_i,
   output logic [DATA_W-1:0] d_rdata_o,
   output logic              d_done_o,
   output logic              stall_req_o,
   output logic [ADDR_W-3:0] sram_addr_o,
   output logic [DATA_W-1:0] sram_wdata_o,
   output logic              sram_wdata_oe_o,
   input  logic [DATA_W-1:0] sram_rdata_i,
   output logic              sram_ce_n_o,
   output logic              sram_oe_n_o,
   output logic              sram_we_n_o
);

   arb_state_e        state_q, state_d;
   owner_e            owner_q, owner_d;   // current owner, doubles as last_owner
   logic [ADDR_W-3:0] addr_q, addr_d;
   logic              we_q, we_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
   logic              grant;
   logic              timer_load;
   logic              timer_en;
   logic              timer_done;
   logic              any_req;
   logic              unused_addr_lsbs;

   assign any_req          = if_req_i | d_req_i;
   assign unused_addr_lsbs = ^{if_addr_i[1:0], d_addr_i[1:0]};

   rom_bus_arbiter_sram_cycle_timer #(
      .WAIT_CYCLES (WAIT_CYCLES)
   ) u_timer (
      .clk    (clk),
      .rst    (rst),
      .load_i (timer_load),
      .en_i   (timer_en),
      .done_o (timer_done)
   );

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      addr_d     = addr_q;
      we_d       = we_q;
      wdata_d    = wdata_q;
      if_rdata_d = if_rdata_q;
      d_rdata_d  = d_rdata_q;
      grant      = 1'b0;
      timer_load = 1'b0;
      timer_en   = 1'b0;

      case (state_q)
         ARB_IDLE: begin
            if (any_req) begin
               grant   = 1'b1;
               state_d = ARB_SETUP;
            end
         end
         ARB_SETUP: begin
            timer_load = 1'b1;
            state_d    = ARB_ACCESS;
         end
         ARB_ACCESS: begin
            if (timer_done) begin
               state_d = ARB_HOLD;
               if (!we_q) begin
                  if (owner_q == OWN_DATA) begin
                     d_rdata_d = sram_rdata_i;
                  end else begin
                     if_rdata_d = sram_rdata_i;
                  end
               end
            end else begin
               timer_en = 1'b1;
            end
         end
         ARB_HOLD: begin
            // Back-to-back grant: the next SETUP follows HOLD directly.
            if (any_req) begin
               grant   = 1'b1;
               state_d = ARB_SETUP;
            end else begin
               state_d = ARB_IDLE;
            end
         end
         default: state_d = ARB_IDLE;
      endcase

      if (grant) begin
         owner_d = pick_owner(if_req_i, d_req_i, owner_q);
         if (owner_d == OWN_DATA) begin
            addr_d  = d_addr_i[ADDR_W-1:2];
            we_d    = d_we_i;
            wdata_d = d_wdata_i;
         end else begin
            addr_d = if_addr_i[ADDR_W-1:2];
            we_d   = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ARB_IDLE;
         owner_q    <= OWN_FETCH;
         addr_q     <= '0;
         we_q       <= 1'b0;
         wdata_q    <= '0;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         addr_q     <= addr_d;
         we_q       <= we_d;
         wdata_q    <= wdata_d;
         if_rdata_q <= if_rdata_d;
         d_rdata_q  <= d_rdata_d;
      end
   end

   // Strobes decode straight from state, so a reset releases them on the next cycle.
   assign sram_ce_n_o     = (state_q == ARB_IDLE) ? STROBE_INACTIVE : STROBE_ACTIVE;
   assign sram_oe_n_o     = ((state_q == ARB_ACCESS) && !we_q) ? STROBE_ACTIVE : STROBE_INACTIVE;
   assign sram_we_n_o     = ((state_q == ARB_ACCESS) && we_q) ? STROBE_ACTIVE : STROBE_INACTIVE;
   assign sram_wdata_oe_o = (state_q == ARB_ACCESS) && we_q;
   assign sram_addr_o     = addr_q;
   assign sram_wdata_o    = wdata_q;

   assign if_valid_o  = (state_q == ARB_HOLD) && (owner_q == OWN_FETCH);
   assign d_done_o    = (state_q == ARB_HOLD) && (owner_q == OWN_DATA);
   assign if_rdata_o  = if_rdata_q;
   assign d_rdata_o   = d_rdata_q;
   assign stall_req_o = (d_req_i & ~d_done_o) | (if_req_i & ~if_valid_o);

endmodule
